if_fetch_unit: RTL and testbench

//  Instruction-fetch stage. Owns the program counter and drives the 8-bit byte address of the

---
 rtl/if_fetch_unit.sv | 103 ++++++++++
 tb/tb_if_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the IF/ID pipeline register, with stall, branch flush and halt-on-zero-word handling.
module if_fetch_unit #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] PC_RESET  = '0,
  parameter int                PC_STEP   = 4,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] branch_tgt_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_instr_i,
  output logic [ADDR_W-1:0] if_id_pc_o,
  output logic [31:0]       if_id_instr_o,
  output logic              if_id_valid_o,
  output logic              halted_o,
  output logic [15:0]       fetch_cnt_o
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_if_id_pc;
  logic [31:0]       r_if_id_instr;
  logic              r_if_id_valid;
  logic              r_halted;
  logic [15:0]       r_fetch_cnt;

  logic [ADDR_W-1:0] w_tgt;
  logic              w_zero_word;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign w_tgt       = branch_tgt_i & ALIGN_MASK;
  assign w_zero_word = (imem_instr_i == 32'h0);

  // NOTE: every state register uses non-blocking assignments so all updates
  // in this block see the pre-edge values of r_pc and r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= PC_RESET;
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_cnt   <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_RUN;
          if (flush_i) r_pc <= w_tgt;
        end
        S_RUN: begin
          if (flush_i) begin
            r_pc          <= w_tgt;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
          end else if (stall_i) begin
            r_pc <= r_pc;
          end else if (w_zero_word) begin
            r_state       <= S_HALT;
            r_halted      <= 1'b1;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
          end else begin
            r_pc          <= r_pc + PC_INC;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= imem_instr_i;
            r_if_id_valid <= 1'b1;
            if (r_fetch_cnt != 16'hFFFF) r_fetch_cnt <= r_fetch_cnt + 16'd1;
          end
        end
        S_HALT: begin
          // A taken branch means the zero word was on a wrong path; resume there.
          if (flush_i) begin
            r_pc     <= w_tgt;
            r_halted <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign imem_addr_o   = r_pc;
  assign if_id_pc_o    = r_if_id_pc;
  assign if_id_instr_o = r_if_id_instr;
  assign if_id_valid_o = r_if_id_valid;
  assign halted_o      = r_halted;
  assign fetch_cnt_o   = r_fetch_cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: sequential fetch, stall, flush, halt, wrap,
// asynchronous reset and fetch-counter saturation against hand-computed values.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic [7:0]  branch_tgt_i;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [7:0]  if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        halted_o;
  logic [15:0] fetch_cnt_o;

  logic [31:0] mem [64];
  int          n_checks;
  int          n_fails;

  if_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .branch_tgt_i (branch_tgt_i),
    .imem_addr_o  (imem_addr_o),
    .imem_instr_i (imem_instr_i),
    .if_id_pc_o   (if_id_pc_o),
    .if_id_instr_o(if_id_instr_o),
    .if_id_valid_o(if_id_valid_o),
    .halted_o     (halted_o),
    .fetch_cnt_o  (fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb imem_instr_i = mem[imem_addr_o[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [7:0] pc, input logic [31:0] instr,
                          input logic valid);
    check({tag, ".pc"}, 32'(if_id_pc_o), 32'(pc));
    check({tag, ".instr"}, if_id_instr_o, instr);
    check({tag, ".valid"}, 32'(if_id_valid_o), 32'(valid));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, ".addr"}, 32'(imem_addr_o), 32'h00);
    chk_ifid(tag, 8'h00, NOP, 1'b0);
    check({tag, ".halted"}, 32'(halted_o), 32'h0);
    check({tag, ".cnt"}, 32'(fetch_cnt_o), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h4000_0033;
    mem[4] = 32'h0000_0000;
    stall_i = 1'b0;
    flush_i = 1'b0;
    branch_tgt_i = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    chk_reset("rst");
    #11 rst_n = 1'b1;

    // Boot bubble, then sequential fetch with a two-cycle stall at 0x08
    step();
    check("boot.valid", 32'(if_id_valid_o), 32'h0);
    check("boot.addr", 32'(imem_addr_o), 32'h00);
    step();
    chk_ifid("f0", 8'h00, 32'h0050_0093, 1'b1);
    check("f0.cnt", 32'(fetch_cnt_o), 32'd1);
    step();
    chk_ifid("f1", 8'h04, 32'h00A0_0113, 1'b1);
    check("f1.addr", 32'(imem_addr_o), 32'h08);
    stall_i = 1'b1;
    repeat (2) begin
      step();
      check("stall.addr", 32'(imem_addr_o), 32'h08);
      chk_ifid("stall", 8'h04, 32'h00A0_0113, 1'b1);
      check("stall.cnt", 32'(fetch_cnt_o), 32'd2);
    end
    stall_i = 1'b0;
    step();
    chk_ifid("f2", 8'h08, 32'h0020_81B3, 1'b1);
    check("f2.cnt", 32'(fetch_cnt_o), 32'd3);
    check("f2.addr", 32'(imem_addr_o), 32'h0C);

    // Flush overrides stall; unaligned target bits dropped
    flush_i = 1'b1; stall_i = 1'b1; branch_tgt_i = 8'h21;
    step();
    check("fl.addr", 32'(imem_addr_o), 32'h20);
    chk_ifid("fl", 8'h0C, NOP, 1'b0);
    check("fl.cnt", 32'(fetch_cnt_o), 32'd3);
    flush_i = 1'b0; stall_i = 1'b0;
    step();
    chk_ifid("f20", 8'h20, 32'h1000_0008, 1'b1);
    check("f20.cnt", 32'(fetch_cnt_o), 32'd4);

    // Halt on zero word at 0x10, stall ignored while halted, flush resumes
    flush_i = 1'b1; branch_tgt_i = 8'h0C;
    step();
    flush_i = 1'b0;
    step();
    chk_ifid("f0c", 8'h0C, 32'h4000_0033, 1'b1);
    step();
    check("halt.halted", 32'(halted_o), 32'h1);
    check("halt.addr", 32'(imem_addr_o), 32'h10);
    check("halt.valid", 32'(if_id_valid_o), 32'h0);
    check("halt.instr", if_id_instr_o, NOP);
    check("halt.cnt", 32'(fetch_cnt_o), 32'd5);
    stall_i = 1'b1;
    step();
    check("hold.halted", 32'(halted_o), 32'h1);
    check("hold.addr", 32'(imem_addr_o), 32'h10);
    check("hold.cnt", 32'(fetch_cnt_o), 32'd5);
    stall_i = 1'b0; flush_i = 1'b1; branch_tgt_i = 8'h04;
    step();
    check("unhalt.halted", 32'(halted_o), 32'h0);
    check("unhalt.addr", 32'(imem_addr_o), 32'h04);
    check("unhalt.valid", 32'(if_id_valid_o), 32'h0);
    flush_i = 1'b0;
    step();
    chk_ifid("resume", 8'h04, 32'h00A0_0113, 1'b1);
    check("resume.cnt", 32'(fetch_cnt_o), 32'd6);

    // A zero word that is squashed by a flush must not halt
    flush_i = 1'b1; branch_tgt_i = 8'h10;
    step();
    branch_tgt_i = 8'h14;
    step();
    check("sq.halted", 32'(halted_o), 32'h0);
    check("sq.addr", 32'(imem_addr_o), 32'h14);
    flush_i = 1'b0;
    step();
    chk_ifid("f14", 8'h14, 32'h1000_0005, 1'b1);
    check("f14.cnt", 32'(fetch_cnt_o), 32'd7);

    // Re-enter halt, then reset asynchronously while halted
    flush_i = 1'b1; branch_tgt_i = 8'h10;
    step();
    flush_i = 1'b0;
    step();
    check("rehalt", 32'(halted_o), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_halt");
    #2 rst_n = 1'b1;
    step();
    check("boot2.valid", 32'(if_id_valid_o), 32'h0);
    check("boot2.addr", 32'(imem_addr_o), 32'h00);
    step();
    chk_ifid("b2f0", 8'h00, 32'h0050_0093, 1'b1);

    // Wrap from 0xFC back to 0x00
    mem[4] = 32'h1000_0004;
    flush_i = 1'b1; branch_tgt_i = 8'hF8;
    step();
    flush_i = 1'b0;
    step();
    chk_ifid("fF8", 8'hF8, 32'h1000_003E, 1'b1);
    step();
    chk_ifid("fFC", 8'hFC, 32'h1000_003F, 1'b1);
    check("wrap.addr", 32'(imem_addr_o), 32'h00);
    check("wrap.halted", 32'(halted_o), 32'h0);
    check("wrap.cnt", 32'(fetch_cnt_o), 32'd3);

    // Asynchronous reset in the middle of a stall
    stall_i = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_stall");
    #2 rst_n = 1'b1;
    stall_i = 1'b0;
    step();
    check("boot3.valid", 32'(if_id_valid_o), 32'h0);
    step();
    chk_ifid("b3f0", 8'h00, 32'h0050_0093, 1'b1);
    check("b3f0.cnt", 32'(fetch_cnt_o), 32'd1);

    // Fetch counter saturation
    repeat (65533) step();
    check("sat.pre", 32'(fetch_cnt_o), 32'h0000_FFFE);
    step();
    check("sat.max", 32'(fetch_cnt_o), 32'h0000_FFFF);
    repeat (3) step();
    check("sat.hold", 32'(fetch_cnt_o), 32'h0000_FFFF);
    check("sat.valid", 32'(if_id_valid_o), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
